uart_tx_core: RTL

- Serial UART transmitter, 8N1 framing, LSB first, line idles high.
- Loads a byte on a start request and shifts it out on `tx` at the configured baud rate.
- Reports busy/done status back to `uart_controller`.
- It is the transmit-side counterpart to the receiver that `uart_controller` drives from `rx`. The two are wired back-to-back in loopback benches.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_core_if.sv | 21 ++
 rtl/baud_tick_gen.sv | 30 +++
 rtl/uart_tx_core.sv | 116 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and line idle level.
// Used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int   DATA_BITS          = 8;
    localparam int   OVERSAMPLE_DEFAULT = 16;
    localparam logic LINE_IDLE          = 1'b1;

endpackage

// File: rtl/uart_tx_core_if.sv
// Transmit request/status bundle between the controller (master) and the
// UART transmitter (slave).
interface uart_tx_core_if;
    import uart_pkg::*;

    logic                 start_trig;
    logic [DATA_BITS-1:0] tx_din;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output start_trig, tx_din,
        input  tx, tx_busy, tx_done
    );

    modport slave (
        input  start_trig, tx_din,
        output tx, tx_busy, tx_done
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-cycle tick every CLK_FREQ/(BAUD*OVERSAMPLE)
// clocks, with a synchronous clear so a frame can start on an exact phase.
module baud_tick_gen #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter, 8N1, LSB first, idle-high line, registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_core_if.slave  bus
);
    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [2:0]      IDX_LAST = 3'(DATA_BITS - 1);

    uart_state_t          state;
    logic [OS_W-1:0]      os_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick;
    logic                 tick_clr;
    logic                 bit_done;
    logic [2:0]           idx_next;

    // Restarting the tick phase on acceptance makes the start bit exactly one bit long.
    assign tick_clr = (state == IDLE) && bus.start_trig;
    assign bit_done = tick && (os_cnt == OS_LAST);
    assign idx_next = bit_idx + 3'd1;

    baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            os_cnt      <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            bus.tx      <= LINE_IDLE;
            bus.tx_busy <= 1'b0;
            bus.tx_done <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;
            if (state != IDLE && tick) begin
                os_cnt <= bit_done ? '0 : os_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    bus.tx      <= LINE_IDLE;
                    bus.tx_busy <= 1'b0;
                    if (bus.start_trig) begin
                        shreg       <= bus.tx_din;
                        os_cnt      <= '0;
                        bit_idx     <= '0;
                        bus.tx      <= ~LINE_IDLE;
                        bus.tx_busy <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_idx <= '0;
                        bus.tx  <= shreg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            bus.tx <= ^shreg;
                            state  <= PARITY;
`else
                            bus.tx <= LINE_IDLE;
                            state  <= STOP;
`endif
                        end else begin
                            bit_idx <= idx_next;
                            bus.tx  <= shreg[idx_next];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        bus.tx <= LINE_IDLE;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bus.tx      <= LINE_IDLE;
                        bus.tx_busy <= 1'b0;
                        bus.tx_done <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    bus.tx      <= LINE_IDLE;
                    bus.tx_busy <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
